// File: rtl/mem_access_unit.sv
// RV32I memory-stage data-port initiator: word-aligned load/store requests, stall until mem_resp.
// Optional build macro MEM_MISALIGN_TRAP_EN suppresses misaligned SH/SW/LW and raises a one-cycle misalign flag.
package mem_access_pkg;
    typedef struct packed {
        logic [6:0] opcode;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [2:0]  funct3;
        ctrl_t       ctrl;
    } stage_regs;
endpackage

module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  stage_regs   regs_in,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata_b,
    output logic        stall,
    output logic        misalign
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Lane enables; SH at off=3 loses its upper lane to the 4-bit truncation.
    function automatic logic [3:0] calc_be(input logic is_load, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [3:0] be;
        if (is_load) begin
            be = 4'b1111;
        end else begin
            case (f3)
                3'b000:  be = 4'b0001 << off;
                3'b001:  be = 4'b0011 << off;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic is_load, input logic [2:0] f3,
                                               input logic [31:0] rs2);
        logic [31:0] wd;
        if (is_load) begin
            wd = 32'd0;
        end else begin
            case (f3)
                3'b000:  wd = {4{rs2[7:0]}};
                3'b001:  wd = {2{rs2[15:0]}};
                default: wd = rs2;
            endcase
        end
        return wd;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic is_load;
    logic is_store;
    logic req;
    logic req_mis;
    logic req_issue;

    assign is_load  = (regs_in.ctrl.opcode == OP_LOAD);
    assign is_store = (regs_in.ctrl.opcode == OP_STORE);
    assign req      = valid_in && (is_load || is_store);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    // LW and SW share funct3 010; halfword traps only for the store.
    assign req_mis = req && ((is_store && (regs_in.funct3 == 3'b001) && regs_in.alu[0]) ||
                             ((regs_in.funct3 == 3'b010) && (regs_in.alu[1:0] != 2'b00)));
    assign misalign_d = (state_q == IDLE) && req_mis;
    assign misalign   = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign req_mis  = 1'b0;
    assign misalign = 1'b0;
`endif

    assign req_issue = req && !req_mis;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_issue) begin
                    state_d = BUSY;
                    rd_d    = is_load;
                    wr_d    = is_store;
                    addr_d  = {regs_in.alu[31:2], 2'b00};
                    be_d    = calc_be(is_load, regs_in.funct3, regs_in.alu[1:0]);
                    wdata_d = calc_wdata(is_load, regs_in.funct3, regs_in.rs2);
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall           = ((state_q == IDLE) && req_issue) || (state_q == BUSY);
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_address     = addr_q;
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;
    assign rdata_b         = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected requests/load words, a monitor pops on strobe edges.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ADD   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    stage_regs   regs_in;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] rdata_b;
    logic        stall;
    logic        misalign;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .regs_in(regs_in),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .rdata_b(rdata_b), .stall(stall), .misalign(misalign)
    );

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] last_load;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the memory port should see for one instruction.
    function automatic req_t model_req(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [31:0] alu, input logic [31:0] rs2);
        req_t r;
        int   off;
        off     = int'(alu % 4);
        r.rd    = (opc == OPC_LOAD);
        r.addr  = alu - (alu % 4);
        r.be    = 4'hF;
        r.wdata = rs2;
        if (!r.rd && f3 == 3'd0) begin
            r.be    = 4'((1 << off) % 16);
            r.wdata = rs2[7:0] * 32'h0101_0101;
        end else if (!r.rd && f3 == 3'd1) begin
            r.be    = 4'((3 << off) % 16);
            r.wdata = rs2[15:0] * 32'h0001_0001;
        end
        return r;
    endfunction

    function automatic bit model_trap(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [31:0] alu);
`ifdef MEM_MISALIGN_TRAP_EN
        if (opc == OPC_STORE && f3 == 3'd1 && (alu % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (alu % 4) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Monitor: a rising strobe is a new request, a falling strobe ends an access.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        req_t e;
        logic [31:0] er;
        if ((mem_read || mem_write) && !prev_strobe) begin
            if (exp_req.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_request actual=0x%08h required=none", mem_address);
            end else begin
                e = exp_req.pop_front();
                check("req_read", {31'd0, mem_read}, {31'd0, e.rd});
                check("req_write", {31'd0, mem_write}, {31'd0, !e.rd});
                check("req_addr", mem_address, e.addr);
                check("req_be", {28'd0, mem_byte_enable}, {28'd0, e.be});
                if (!e.rd) check("req_wdata", mem_wdata, e.wdata);
            end
        end
        if (!(mem_read || mem_write) && prev_strobe) begin
            if (exp_rdata.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion actual=0x%08h required=none", rdata_b);
            end else begin
                er = exp_rdata.pop_front();
                check("rdata_b_done", rdata_b, er);
            end
        end
        prev_strobe <= mem_read || mem_write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_regs();
        regs_in.alu         = $urandom;
        regs_in.rs2         = $urandom;
        regs_in.funct3      = 3'($urandom_range(0, 7));
        regs_in.ctrl.opcode = ($urandom_range(0, 1) == 0) ? OPC_LOAD : OPC_STORE;
    endtask

    task automatic mem_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] rs2, input int k, input logic [31:0] rdata,
                          input bit resp_at_t);
        req_t e;
        e = model_req(opc, f3, alu, rs2);
        valid_in            = 1'b1;
        regs_in.alu         = alu;
        regs_in.rs2         = rs2;
        regs_in.funct3      = f3;
        regs_in.ctrl.opcode = opc;
        mem_resp            = resp_at_t;
        mem_rdata           = $urandom;
        #1;
        if (model_trap(opc, f3, alu)) begin
            check("trap_stall", {31'd0, stall}, 32'd0);
            tick();
            valid_in = 1'b0;
            mem_resp = 1'b0;
            #1;
            check("trap_misalign_t1", {31'd0, misalign}, 32'd1);
            check("trap_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
            check("trap_rdata_b", rdata_b, last_load);
            tick();
            check("trap_misalign_t2", {31'd0, misalign}, 32'd0);
            return;
        end
        check("req_stall_t", {31'd0, stall}, 32'd1);
        exp_req.push_back(e);
        tick();
        for (int j = 1; j <= k; j++) begin
            randomize_regs();
            valid_in  = (j < k) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_resp  = (j == k);
            mem_rdata = (j == k) ? rdata : $urandom;
            #1;
            check("busy_stall", {31'd0, stall}, 32'd1);
            check("busy_strobes", {30'd0, mem_read, mem_write}, {30'd0, e.rd, !e.rd});
            check("busy_addr", mem_address, e.addr);
            check("busy_be", {28'd0, mem_byte_enable}, {28'd0, e.be});
            check("busy_misalign", {31'd0, misalign}, 32'd0);
            if (j == k) begin
                if (e.rd) last_load = rdata;
                exp_rdata.push_back(last_load);
            end
            tick();
        end
        valid_in = 1'b0;
        mem_resp = 1'($urandom_range(0, 1));
        #1;
        check("done_stall", {31'd0, stall}, 32'd0);
        check("done_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("done_rdata_b", rdata_b, last_load);
        tick();
    endtask

    task automatic nonmem_op();
        valid_in            = 1'b1;
        regs_in.alu         = $urandom;
        regs_in.rs2         = $urandom;
        regs_in.funct3      = 3'd0;
        regs_in.ctrl.opcode = OPC_ADD;
        mem_resp            = 1'b1;
        mem_rdata           = $urandom;
        #1;
        check("nonmem_stall", {31'd0, stall}, 32'd0);
        tick();
        valid_in = 1'b0;
        mem_resp = 1'b0;
        #1;
        check("nonmem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("nonmem_rdata_b", rdata_b, last_load);
        tick();
    endtask

    task automatic reset_mid_access();
        req_t e;
        e = model_req(OPC_LOAD, 3'd2, 32'h400, 32'd0);
        valid_in            = 1'b1;
        regs_in.alu         = 32'h400;
        regs_in.funct3      = 3'd2;
        regs_in.ctrl.opcode = OPC_LOAD;
        mem_resp            = 1'b0;
        #1;
        check("rst_mid_stall_t", {31'd0, stall}, 32'd1);
        exp_req.push_back(e);
        tick();
        valid_in = 1'b0;
        rst      = 1'b1;
        last_load = 32'd0;
        exp_rdata.push_back(32'd0);
        #1;
        check("rst_mid_busy_read", {31'd0, mem_read}, 32'd1);
        tick();
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mid_stall", {31'd0, stall}, 32'd0);
        check("rst_mid_rdata_b", rdata_b, 32'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        check("rst_late_resp_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_late_resp_rdata_b", rdata_b, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] alu;
        rst       = 1'b1;
        valid_in  = 1'b0;
        regs_in   = '0;
        mem_resp  = 1'b0;
        mem_rdata = 32'd0;
        last_load = 32'd0;
        tick();
        tick();
        check("reset_read", {31'd0, mem_read}, 32'd0);
        check("reset_write", {31'd0, mem_write}, 32'd0);
        check("reset_addr", mem_address, 32'd0);
        check("reset_be", {28'd0, mem_byte_enable}, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_rdata_b", rdata_b, 32'd0);
        check("reset_misalign", {31'd0, misalign}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        tick();

        mem_op(OPC_LOAD, 3'd2, 32'h100, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);
        mem_op(OPC_STORE, 3'd0, 32'h203, 32'h0000_00A5, 4, 32'd0, 1'b1);
        mem_op(OPC_STORE, 3'd1, 32'h302, 32'h0000_1234, 2, 32'd0, 1'b0);
        mem_op(OPC_STORE, 3'd1, 32'h303, 32'h0000_5678, 1, 32'd0, 1'b0);
        nonmem_op();
        reset_mid_access();
        mem_op(OPC_LOAD, 3'd2, 32'h101, 32'd0, 1, 32'h1357_9BDF, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0, 1: begin
                    opc = OPC_LOAD;
                    f3  = 3'($urandom_range(0, 5));
                    if (f3 == 3'd3) f3 = 3'd2;
                end
                2, 3: begin
                    opc = OPC_STORE;
                    f3  = 3'($urandom_range(0, 2));
                end
                default: opc = OPC_ADD;
            endcase
            alu = $urandom;
            if (opc == OPC_ADD) begin
                nonmem_op();
            end else begin
                mem_op(opc, f3, alu, $urandom, $urandom_range(1, 5), $urandom,
                       1'($urandom_range(0, 1)));
            end
        end

        tick();
        check("req_queue_drained", exp_req.size(), 32'd0);
        check("rdata_queue_drained", exp_rdata.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-port initiator for the pipelined RV32I core. It takes the EX/MEM stage register and issues word-aligned load/store requests with byte enables on the data-memory port. It holds the pipeline with `stall` until `mem_resp` arrives, then presents the raw load word on `rdata_b` for the writeback stage's load masking.

## Interface
- No parameters; data and address width is fixed at 32.
- Reset is synchronous and active-high; the block uses one clock.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  `regs_in` holds a live instruction.
- `regs_in`  in  `stage_regs`  EX/MEM register; the block uses `alu` (effective address), `rs2` (store data), `funct3`, `ctrl.opcode`.
- `mem_resp`  in  1  data memory has completed the outstanding request.
- `mem_rdata`  in  32  data memory read word, valid with `mem_resp`.
- `mem_read`  out  1  load request strobe.
- `mem_write`  out  1  store request strobe.
- `mem_address`  out  32  `{alu[31:2], 2'b00}`.
- `mem_byte_enable`  out  4  store byte lanes; `4'b1111` on loads.
- `mem_wdata`  out  32  lane-shifted store data.
- `rdata_b`  out  32  last captured load word, raw and unmasked.
- `stall`  out  1  freezes PC and all upstream stage registers.
- `misalign`  out  1  one-cycle misaligned-access flag; constant 0 unless the macro in Configuration is defined.

## Operation
- A request is `valid_in` with opcode LOAD or STORE. Every other opcode passes through with `stall` = 0 and issues no request.
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - If a request is present: register the address, byte enables and wdata, and assert `mem_read` or `mem_write`. Go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - Hold the strobes, address, byte enables and wdata stable until `mem_resp` = 1.
  - On `mem_resp`: drop the strobes. If the request was a load, capture `mem_rdata` into `rdata_b`. Go to DONE.
- **DONE**
  - Lasts one cycle with `stall` = 0 so the pipeline advances. Unconditionally return to IDLE.
- `stall` = (IDLE & request) | BUSY. It is combinational.
- Byte enables and write data by funct3, with off = `alu[1:0]`:
  - SB: `4'b0001 << off`; wdata = `rs2[7:0]` replicated to all four bytes.
  - SH: `4'b0011 << off`; wdata = `rs2[15:0]` replicated to both halves.
  - SW: `4'b1111`; wdata = `rs2`.
- Loads always read the full word. The writeback stage masks and sign-extends it.
- `rdata_b` keeps its value until the next load completes. Stores and non-memory instructions leave it unchanged.
- Boundary conditions:
  - `mem_resp` in IDLE or DONE is ignored.
  - `mem_resp` in the same cycle as the request enters IDLE is ignored, because the request is not yet issued.
  - A change on `regs_in` while BUSY is ignored, because the request was latched in IDLE.
  - `rst` in any state forces IDLE and drops the strobes. A late `mem_resp` after reset is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_read` = `mem_write` = 0.
  - `mem_address` = 0, `mem_byte_enable` = 0, `mem_wdata` = 0.
  - `rdata_b` = 0.
  - `misalign` = 0.
- Cycle sequence, with the request present in cycle t:
  - Strobes are visible from cycle t+1.
  - If `mem_resp` arrives in cycle t+k (k ≥ 1): strobes drop and state is DONE in t+k+1; `rdata_b` is valid from t+k+1.
  - `stall` is high for cycles t through t+k; the pipeline advances at the end of t+k+1.
- Minimum access costs 3 cycles (request, BUSY with response, DONE). Back-to-back memory instructions are therefore separated by at least one IDLE cycle.
- At most one request is outstanding at a time.

## Configuration
- Macro `MEM_MISALIGN_TRAP_EN`.
- Defined: an SH with `alu[0]` = 1, or an SW or LW with `alu[1:0]` ≠ 0, does not issue a request.
  - Stay in IDLE, assert `misalign` for one cycle (registered, cycle t+1), and hold `stall` = 0.
  - `rdata_b` is unchanged.
- Not defined:
  - `misalign` is tied to 0.
  - The low address bits are dropped and the access is issued word-aligned, using the shifted lanes given above. An out-of-word SH lane (off = 3) produces `mem_byte_enable` = `4'b1000`, because the upper bit is truncated.

## Test plan
- **Load, k = 1:** LW at address 0x100; `mem_rdata` = 0xDEADBEEF with `mem_resp` in t+1 -> `mem_read` high only in t+1, `mem_address` = 0x100, `stall` high in t and t+1, `rdata_b` = 0xDEADBEEF from t+2.
- **Store byte with wait states:** SB with address 0x203, `rs2` = 0x000000A5, `mem_resp` in t+4 -> `mem_byte_enable` = 4'b1000, `mem_wdata` = 0xA5A5A5A5, `mem_address` = 0x200, outputs stable t+1..t+4, `rdata_b` unchanged.
- **Store half:** SH with address 0x302, `rs2` = 0x1234 -> `mem_byte_enable` = 4'b1100, `mem_wdata` = 0x12341234.
- **Non-memory plus spurious response:** ADD instruction with `mem_resp` pulsed in IDLE -> `stall` = 0, no strobes, `rdata_b` unchanged.
- **Reset mid-access:** `rst` in BUSY, then `mem_resp` next cycle -> IDLE, strobes 0, `rdata_b` = 0, response ignored.
- **Macro on:** LW at address 0x101 -> no `mem_read`, `misalign` = 1 in t+1 only, `stall` = 0. Macro off: the same access reads 0x100.
